// File: rtl/router_output_arbiter.sv
// Router output port arbiter.
// Several packet FIFOs share one byte-wide output. In IDLE a round-robin pick
// chooses the next FIFO. In XFER the granted FIFO's packet is streamed one byte
// per accepted cycle, and the entry is popped on the last byte. Data and
// handshake outputs are combinational from registered state, so a byte reaches
// the output in the same cycle that its index is driven.
module router_output_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4,
  parameter int GNT_SZ    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        rempty,
  input  logic [NUM_IN*UWIDTH-1:0] rdata,
  input  logic [NUM_IN-1:0]        port_en,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        rinc,
  output logic [PTR_IN_SZ-1:0]     raddr_in,
  output logic                     out_valid,
  output logic [UWIDTH-1:0]        out_data,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [GNT_SZ-1:0]        grant,
  output logic                     busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Index of the final byte of a packet.
  localparam logic [PTR_IN_SZ-1:0] LAST_IDX = PTR_IN_SZ'(WIDTH - 1);
  // After reset, the highest index counts as the most recent winner, so FIFO 0
  // has first priority.
  localparam logic [GNT_SZ-1:0] GRANT_INIT = GNT_SZ'(NUM_IN - 1);

  state_t               state;
  state_t               next_state;
  logic [PTR_IN_SZ-1:0] byte_idx;
  logic [GNT_SZ-1:0]    last_grant;
  logic [NUM_IN-1:0]    eligible;
  logic                 any_eligible;
  logic [GNT_SZ-1:0]    pick;
  logic [GNT_SZ-1:0]    cand_idx;
  logic                 last_byte;

  assign eligible     = port_en & ~rempty;
  assign any_eligible = |eligible;
  assign last_byte    = (byte_idx == LAST_IDX);

  // Round-robin pick. Scan from the farthest candidate to the nearest one, so
  // the nearest eligible index after last_grant is written last and wins.
  always_comb begin
    pick     = '0;
    cand_idx = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      cand_idx = GNT_SZ'((int'(last_grant) + k) % NUM_IN);
      pick     = eligible[cand_idx] ? cand_idx : pick;
    end
  end

  // Next-state logic and handshake/data outputs. Every output stays 0 outside
  // XFER, and the pop pulse is limited to the accepted final byte.
  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    busy       = 1'b0;
    raddr_in   = '0;
    out_data   = '0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    rinc       = '0;
    case (state)
      IDLE: begin
        if (any_eligible) begin
          next_state = XFER;
        end else begin
          next_state = IDLE;
        end
      end
      XFER: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        raddr_in  = byte_idx;
        out_data  = rdata[int'(grant)*UWIDTH +: UWIDTH];
        out_sop   = (byte_idx == '0);
        out_eop   = last_byte;
        if (out_ready && last_byte) begin
          rinc[grant] = 1'b1;
          next_state  = IDLE;
        end else begin
          next_state = XFER;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register. A reset during XFER abandons the packet without a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant, byte index and round-robin pointer. The grant is captured only in
  // IDLE, so changes on port_en or rempty cannot move a packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= '0;
      grant      <= '0;
      last_grant <= GRANT_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            grant    <= pick;
            byte_idx <= '0;
          end
        end
        XFER: begin
          if (out_ready) begin
            if (last_byte) begin
              byte_idx   <= '0;
              last_grant <= grant;
            end else begin
              byte_idx <= byte_idx + PTR_IN_SZ'(1);
            end
          end
        end
        default: begin
          byte_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter. The bench models the FIFOs as packet
// stores. A cycle recorder builds packets from the accepted bytes. Each test
// task compares those packets with round-robin and framing rules that the bench
// works out for itself.
module tb_router_output_arbiter;
  localparam int N = 4;
  localparam int W = 11;
  localparam int SLOTS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rempty;
  logic [31:0] rdata;
  logic [3:0]  port_en;
  logic        out_ready;
  logic [3:0]  rinc;
  logic [3:0]  raddr_in;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  grant;
  logic        busy;

  router_output_arbiter #(.NUM_IN(4), .WIDTH(11), .UWIDTH(8), .PTR_IN_SZ(4), .GNT_SZ(2)) dut (
    .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata), .port_en(port_en),
    .out_ready(out_ready), .rinc(rinc), .raddr_in(raddr_in), .out_valid(out_valid),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // FIFO model: each FIFO is a ring of whole packets.
  logic [7:0] mem [N][SLOTS*W];
  int wr_pkt [N];
  int rd_pkt [N];

  function automatic int fcnt(int n);
    return wr_pkt[n] - rd_pkt[n];
  endfunction

  function automatic logic [7:0] fbyte(int n, int b);
    return mem[n][(rd_pkt[n] % SLOTS) * W + b];
  endfunction

  task automatic push_pkt(int n);
    for (int b = 0; b < W; b++) mem[n][(wr_pkt[n] % SLOTS) * W + b] = 8'($urandom);
    wr_pkt[n]++;
  endtask

  // Packet record built from what the DUT does.
  typedef struct {
    int         g;
    logic [3:0] elig;
    int         start;
    int         stop;
    int         nbytes;
    int         rinc_cnt;
    logic [3:0] rinc_val;
    logic [4:0] bad;   // sop, eop, data/trunc, hold/grant-move, rinc timing
  } pkt_t;

  pkt_t       pkts[$];
  pkt_t       cur;
  bit         in_pkt;
  int         cyc = 0;
  int         stray_rinc, idle_bad;
  logic [3:0] last_elig;
  bit         prev_stall;
  logic [3:0] p_raddr;
  logic [7:0] p_data;
  logic       s_valid, s_ready, s_sop, s_eop, s_busy;
  logic [3:0] s_raddr, s_rinc;
  logic [7:0] s_data;
  logic [1:0] s_grant;

  task automatic drive_fifos();
    for (int n = 0; n < N; n++) begin
      rempty[n] = (fcnt(n) == 0);
      rdata[n*8 +: 8] = (fcnt(n) > 0 && int'(raddr_in) < W) ? fbyte(n, int'(raddr_in))
                                                           : (8'hE0 | 8'(n));
    end
  endtask

  task automatic observe();
    cyc++;
    s_valid = out_valid; s_ready = out_ready; s_sop = out_sop; s_eop = out_eop;
    s_busy = busy; s_raddr = raddr_in; s_rinc = rinc; s_data = out_data; s_grant = grant;
    if (busy !== out_valid) idle_bad++;
    if (!out_valid) begin
      last_elig = port_en & ~rempty;
      if (out_sop || out_eop || busy || rinc != 4'b0) idle_bad++;
    end
    if (out_valid && !in_pkt) begin
      in_pkt = 1'b1;
      cur.g = int'(grant); cur.elig = last_elig; cur.start = cyc; cur.stop = 0;
      cur.nbytes = 0; cur.rinc_cnt = 0; cur.rinc_val = 4'b0; cur.bad = 5'b0;
    end
    if (in_pkt) begin
      if (!out_valid) cur.bad[2] = 1'b1;
      if (prev_stall && (raddr_in !== p_raddr || out_data !== p_data)) cur.bad[3] = 1'b1;
      if (grant !== 2'(cur.g)) cur.bad[3] = 1'b1;
      if (out_sop !== (cur.nbytes == 0)) cur.bad[0] = 1'b1;
      if (out_eop !== (cur.nbytes == W - 1)) cur.bad[1] = 1'b1;
      if (rinc != 4'b0) begin
        cur.rinc_cnt++;
        cur.rinc_val = rinc;
        if (!(out_valid && out_ready && cur.nbytes == W - 1)) cur.bad[4] = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (cur.nbytes >= W || fcnt(cur.g) == 0 || out_data !== fbyte(cur.g, cur.nbytes))
          cur.bad[2] = 1'b1;
        cur.nbytes++;
        if (cur.nbytes == W) begin
          cur.stop = cyc;
          pkts.push_back(cur);
          in_pkt = 1'b0;
        end
      end
    end else if (rinc != 4'b0) begin
      stray_rinc++;
    end
    for (int n = 0; n < N; n++) if (rinc[n] && fcnt(n) > 0) rd_pkt[n]++;
    prev_stall = out_valid && !out_ready;
    p_raddr = raddr_in;
    p_data = out_data;
  endtask

  task automatic tick();
    drive_fifos();
    #1;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; port_en = 4'hF; out_ready = 1'b1;
    for (int n = 0; n < N; n++) begin wr_pkt[n] = 0; rd_pkt[n] = 0; end
    tick(); tick();
    pkts.delete(); in_pkt = 1'b0; stray_rinc = 0; idle_bad = 0; prev_stall = 1'b0; last_elig = 4'b0;
  endtask

  // Round-robin rule: first eligible index after the previous winner.
  function automatic int rr_next(int prev, logic [3:0] elig);
    for (int k = 1; k <= N; k++) if (elig[(prev + k) % N]) return (prev + k) % N;
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    push_pkt(0); push_pkt(1);
    tick(); tick(); tick();
    tests_run++;
    if ({s_valid, s_busy, s_sop, s_eop} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 0000", {s_valid, s_busy, s_sop, s_eop});
    end
    tests_run++;
    if (s_rinc !== 4'b0) begin tests_failed++; $display("FAIL reset_rinc: got %b want 0000", s_rinc); end
    tests_run++;
    if ({s_grant, s_raddr, s_data} !== 14'b0) begin
      tests_failed++; $display("FAIL reset_data: grant %0d raddr %0d data %h want 0", s_grant, s_raddr, s_data);
    end
    tests_run++;
    if (fcnt(0) != 1) begin tests_failed++; $display("FAIL reset_nopop: got %0d want 1", fcnt(0)); end
  endtask

  task automatic test_single();
    int rel;
    do_reset();
    push_pkt(0);
    rst = 1'b0;
    rel = cyc + 1;
    for (int i = 0; i < 40 && pkts.size() == 0; i++) tick();
    tick(); tick();
    tests_run++;
    if (pkts.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", pkts.size()); end
    if (pkts.size() > 0) begin
      tests_run++;
      if (pkts[0].g != 0) begin tests_failed++; $display("FAIL single_grant: got %0d want 0", pkts[0].g); end
      tests_run++;
      if (pkts[0].start != rel + 1) begin
        tests_failed++; $display("FAIL single_first_arb: got %0d want %0d", pkts[0].start, rel + 1);
      end
      tests_run++;
      if (pkts[0].stop - rel + 1 != 12) begin
        tests_failed++; $display("FAIL single_cycles: got %0d want 12", pkts[0].stop - rel + 1);
      end
      tests_run++;
      if (pkts[0].rinc_cnt != 1 || pkts[0].rinc_val !== 4'b0001) begin
        tests_failed++; $display("FAIL single_rinc: got %0d x %b want 1 x 0001", pkts[0].rinc_cnt, pkts[0].rinc_val);
      end
      tests_run++;
      if (pkts[0].bad !== 5'b0) begin tests_failed++; $display("FAIL single_framing: got %b want 00000", pkts[0].bad); end
    end
    tests_run++;
    if (stray_rinc != 0 || idle_bad != 0 || fcnt(0) != 0) begin
      tests_failed++; $display("FAIL single_idle: stray %0d idle %0d left %0d want 0", stray_rinc, idle_bad, fcnt(0));
    end
  endtask

  task automatic test_round_robin();
    int prev;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int n = 0; n < N; n++) begin push_pkt(n); push_pkt(n); end
    rst = 1'b0;
    for (int i = 0; i < 200 && pkts.size() < 8; i++) tick();
    tick(); tick();
    tests_run++;
    if (pkts.size() != 8) begin tests_failed++; $display("FAIL rr_count: got %0d want 8", pkts.size()); end
    prev = N - 1;
    foreach (pkts[i]) begin
      tests_run++;
      if (pkts[i].g != rr_next(prev, pkts[i].elig)) begin
        tests_failed++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, pkts[i].g, rr_next(prev, pkts[i].elig));
      end
      if (i < 5) begin
        tests_run++;
        if (pkts[i].g != exp_seq[i]) begin
          tests_failed++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, pkts[i].g, exp_seq[i]);
        end
      end
      tests_run++;
      if (pkts[i].rinc_cnt != 1 || pkts[i].rinc_val !== 4'(1 << pkts[i].g) || pkts[i].bad !== 5'b0) begin
        tests_failed++; $display("FAIL rr_packet[%0d]: rinc %0d x %b bad %b want 1 onehot 00000",
                                 i, pkts[i].rinc_cnt, pkts[i].rinc_val, pkts[i].bad);
      end
      if (i > 0) begin
        tests_run++;
        if (pkts[i].start != pkts[i-1].stop + 2) begin
          tests_failed++; $display("FAIL rr_gap[%0d]: got %0d want %0d", i, pkts[i].start, pkts[i-1].stop + 2);
        end
      end
      prev = pkts[i].g;
    end
  endtask

  task automatic test_stall();
    int stall_left;
    logic [7:0] exp5;
    do_reset();
    push_pkt(0);
    exp5 = fbyte(0, 5);
    rst = 1'b0;
    stall_left = 3;
    for (int i = 0; i < 50 && pkts.size() == 0; i++) begin
      out_ready = !(busy && raddr_in == 4'd5 && stall_left > 0);
      if (!out_ready) stall_left--;
      tick();
      if (!s_ready) begin
        tests_run++;
        if (s_raddr !== 4'd5 || s_data !== exp5) begin
          tests_failed++; $display("FAIL stall_hold: raddr %0d data %h want 5 %h", s_raddr, s_data, exp5);
        end
      end
    end
    out_ready = 1'b1;
    tick(); tick();
    tests_run++;
    if (pkts.size() != 1 || stall_left != 0) begin
      tests_failed++; $display("FAIL stall_count: pkts %0d stalls left %0d want 1 0", pkts.size(), stall_left);
    end
    if (pkts.size() > 0) begin
      tests_run++;
      if (pkts[0].stop - pkts[0].start + 1 != 14) begin
        tests_failed++; $display("FAIL stall_len: got %0d want 14", pkts[0].stop - pkts[0].start + 1);
      end
      tests_run++;
      if (pkts[0].bad !== 5'b0 || pkts[0].rinc_cnt != 1 || stray_rinc != 0) begin
        tests_failed++; $display("FAIL stall_framing: bad %b rinc %0d stray %0d want 00000 1 0",
                                 pkts[0].bad, pkts[0].rinc_cnt, stray_rinc);
      end
    end
  endtask

  task automatic test_port_en();
    int prev, n2;
    bit cleared;
    do_reset();
    for (int n = 0; n < N; n++) begin push_pkt(n); push_pkt(n); end
    port_en = 4'b1101;
    rst = 1'b0;
    cleared = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (!cleared && busy && grant == 2'd2 && raddr_in == 4'd4) begin
        port_en = 4'b1001;
        cleared = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (!cleared || pkts.size() != 5) begin
      tests_failed++; $display("FAIL pen_count: cleared %0d pkts %0d want 1 5", cleared, pkts.size());
    end
    prev = N - 1;
    n2 = 0;
    foreach (pkts[i]) begin
      tests_run++;
      if (pkts[i].g == 1 || pkts[i].g != rr_next(prev, pkts[i].elig)) begin
        tests_failed++; $display("FAIL pen_grant[%0d]: got %0d want %0d", i, pkts[i].g, rr_next(prev, pkts[i].elig));
      end
      tests_run++;
      if (pkts[i].rinc_cnt != 1 || pkts[i].bad !== 5'b0) begin
        tests_failed++; $display("FAIL pen_packet[%0d]: rinc %0d bad %b want 1 00000", i, pkts[i].rinc_cnt, pkts[i].bad);
      end
      if (pkts[i].g == 2) n2++;
      prev = pkts[i].g;
    end
    tests_run++;
    if (n2 != 1 || fcnt(1) != 2 || fcnt(2) != 1) begin
      tests_failed++; $display("FAIL pen_fifos: fifo2 grants %0d left1 %0d left2 %0d want 1 2 1", n2, fcnt(1), fcnt(2));
    end
    port_en = 4'hF;
  endtask

  task automatic test_reset_abort();
    int rel;
    do_reset();
    push_pkt(0); push_pkt(0);
    rst = 1'b0;
    for (int i = 0; i < 30 && !(busy && raddr_in == 4'd7); i++) tick();
    tests_run++;
    if (!(busy && raddr_in == 4'd7)) begin
      tests_failed++; $display("FAIL abort_reach: raddr %0d busy %0d want 7 1", raddr_in, busy);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (s_rinc !== 4'b0) begin tests_failed++; $display("FAIL abort_rinc: got %b want 0000", s_rinc); end
    rst = 1'b0;
    in_pkt = 1'b0;
    prev_stall = 1'b0;
    rel = cyc + 1;
    tick();
    tests_run++;
    if ({s_valid, s_busy, s_sop, s_eop, s_rinc, s_grant, s_raddr, s_data} !== 22'b0) begin
      tests_failed++; $display("FAIL abort_outputs: v%0d b%0d sop%0d eop%0d rinc %b g%0d raddr %0d data %h want 0",
                               s_valid, s_busy, s_sop, s_eop, s_rinc, s_grant, s_raddr, s_data);
    end
    tests_run++;
    if (fcnt(0) != 2) begin tests_failed++; $display("FAIL abort_nopop: got %0d want 2", fcnt(0)); end
    for (int i = 0; i < 40 && pkts.size() == 0; i++) tick();
    tests_run++;
    if (pkts.size() == 0) begin
      tests_failed++; $display("FAIL abort_regrant: got 0 packets want 1");
    end else if (pkts[0].g != 0 || pkts[0].start != rel + 1 || pkts[0].bad !== 5'b0 || pkts[0].rinc_cnt != 1) begin
      tests_failed++; $display("FAIL abort_regrant: g %0d start %0d bad %b rinc %0d want 0 %0d 00000 1",
                               pkts[0].g, pkts[0].start, pkts[0].bad, pkts[0].rinc_cnt, rel + 1);
    end
  endtask

  task automatic test_random();
    int pushed, prev, rr_err, pkt_err, n;
    do_reset();
    pushed = 0;
    for (int f = 0; f < N; f++) begin
      n = int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) begin push_pkt(f); pushed++; end
    end
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) port_en = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        n = int'($urandom_range(0, 3));
        if (fcnt(n) < SLOTS - 1) begin push_pkt(n); pushed++; end
      end
      tick();
    end
    port_en = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 1200 && pkts.size() < pushed; i++) tick();
    tick(); tick();
    tests_run++;
    if (pkts.size() != pushed) begin
      tests_failed++; $display("FAIL rand_count: got %0d want %0d", pkts.size(), pushed);
    end
    prev = N - 1;
    rr_err = 0;
    pkt_err = 0;
    foreach (pkts[i]) begin
      if (pkts[i].g != rr_next(prev, pkts[i].elig)) rr_err++;
      if (pkts[i].rinc_cnt != 1 || pkts[i].rinc_val !== 4'(1 << pkts[i].g) || pkts[i].bad !== 5'b0) pkt_err++;
      prev = pkts[i].g;
    end
    tests_run++;
    if (rr_err != 0) begin tests_failed++; $display("FAIL rand_rr: got %0d wrong grants want 0", rr_err); end
    tests_run++;
    if (pkt_err != 0) begin tests_failed++; $display("FAIL rand_packets: got %0d bad packets want 0", pkt_err); end
    tests_run++;
    if (stray_rinc != 0 || idle_bad != 0) begin
      tests_failed++; $display("FAIL rand_idle: stray %0d idle %0d want 0 0", stray_rinc, idle_bad);
    end
  endtask

  initial begin
    rst = 1'b1; port_en = 4'hF; out_ready = 1'b1; rempty = 4'hF; rdata = 32'h0;
    for (int n = 0; n < N; n++) begin wr_pkt[n] = 0; rd_pkt[n] = 0; end
    in_pkt = 1'b0; stray_rinc = 0; idle_bad = 0; prev_stall = 1'b0; last_elig = 4'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_port_en();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/router_output_arbiter.md
ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of input FIFOs sharing this output port.
REQ-002 SHALL have parameter WIDTH, default 11: bytes per FIFO entry, which is one packet.
REQ-003 SHALL have parameter UWIDTH, default 8: bits per byte unit.
REQ-004 SHALL have parameter PTR_IN_SZ, default 4: width of the byte index within an entry.
REQ-005 SHALL have parameter GNT_SZ, default 2: grant index width, equal to ceil(log2(NUM_IN)).
REQ-006 SHALL have ports as follows:
- clk, input, 1: sole clock; all state updates on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- rempty, input, NUM_IN: per-FIFO empty flag; bit n belongs to FIFO n.
- rdata, input, NUM_IN*UWIDTH: per-FIFO read byte; FIFO n occupies bits [n*UWIDTH +: UWIDTH].
- port_en, input, NUM_IN: per-input arbitration enable.
- out_ready, input, 1: downstream accepts the byte this cycle.
- rinc, output, NUM_IN: one-hot pop pulse to the FIFOs.
- raddr_in, output, PTR_IN_SZ: byte index driven to all FIFOs.
- out_valid, output, 1: out_data holds a valid byte.
- out_data, output, UWIDTH: byte from the granted FIFO.
- out_sop, output, 1: current byte is byte 0 of the packet.
- out_eop, output, 1: current byte is byte WIDTH-1 of the packet.
- grant, output, GNT_SZ: index of the granted FIFO.
- busy, output, 1: a packet transfer is in progress.

Function
REQ-007 SHALL implement a two-state machine, IDLE and XFER, plus a registered grant, a byte counter byte_idx and a last_grant pointer.
REQ-008 In IDLE, SHALL compute the eligible set as port_en & ~rempty and, if it is non-empty, register grant as the first eligible index in round-robin order starting at last_grant+1 (modulo NUM_IN), then enter XFER with byte_idx=0.
REQ-009 In IDLE with an empty eligible set, SHALL remain in IDLE and hold out_valid, rinc and busy at 0.
REQ-010 In XFER, SHALL drive raddr_in=byte_idx, out_valid=1, out_data=rdata slice[grant] (combinational, zero-cycle latency), and busy=1.
REQ-011 SHALL assert out_sop when byte_idx==0 and out_eop when byte_idx==WIDTH-1, only while out_valid is 1.
REQ-012 A byte SHALL transfer only in a cycle where out_valid and out_ready are both 1; on a non-final transfer byte_idx increments by 1.
REQ-013 With out_ready=0, SHALL hold raddr_in, out_data, grant and byte_idx unchanged; every byte remains valid until accepted.
REQ-014 On the transfer with byte_idx==WIDTH-1, SHALL pulse rinc[grant]=1 for exactly that cycle, set last_grant=grant, reset byte_idx to 0, and return to IDLE.
REQ-015 rinc SHALL never have more than one bit set, and SHALL be 0 outside the cycle named in REQ-014.
REQ-016 Each packet SHALL occupy WIDTH transfer cycles plus 1 IDLE arbitration cycle; in IDLE, rempty is sampled one cycle after the pop, which lets the FIFO flag update.
REQ-017 Changes to port_en or rempty during XFER SHALL have no effect until the packet completes; a packet is never truncated or re-granted mid-transfer.
REQ-018 When a single input is eligible, it SHALL be granted regardless of last_grant, so back-to-back packets from one FIFO are permitted.
REQ-019 byte_idx SHALL be PTR_IN_SZ bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-020 While rst=1 at a clock edge, SHALL set state=IDLE, byte_idx=0, grant=0, last_grant=NUM_IN-1 (so FIFO 0 has first priority), and drive all outputs to 0.
REQ-021 rst asserted mid-XFER SHALL abort the packet with no rinc pulse, leaving the FIFO entry un-popped.
REQ-022 The first arbitration SHALL occur in the first cycle after rst deasserts.

Verification
REQ-023 The bench SHALL cover: after reset, rempty=4'b1110, port_en=4'hF, out_ready=1 -> grant=0; out_sop on byte 0; out_eop on byte 10; one rinc=4'b0001 pulse; 12 cycles total per packet.
REQ-024 The bench SHALL cover: all 4 FIFOs non-empty with rempty held at 0 -> grants in order 0,1,2,3,0; each grant carries 11 bytes; one rinc pulse per packet.
REQ-025 The bench SHALL cover: out_ready=0 for 3 cycles at byte_idx=5 -> raddr_in=5 and out_data stable for those cycles; eop still on byte 10; no extra bytes.
REQ-026 The bench SHALL cover: port_en=4'b1101 with all FIFOs non-empty -> FIFO 1 is never granted; port_en[2] cleared mid-packet of FIFO 2 -> that packet completes.
REQ-027 The bench SHALL cover: rst pulsed at byte_idx=7 -> next cycle all outputs are 0; no rinc pulse; after release, FIFO 0 is re-granted from byte 0.
